// File: rtl/lp_bus_encoder_pkg.sv
// Shared types and width helpers for the low-power bus encoder.
// Mode encoding is also used by the far-end decoder.
package lp_enc_pkg;

    typedef enum logic [1:0] {
        MODE_BIN  = 2'd0,
        MODE_BINV = 2'd1,
        MODE_T0   = 2'd2,
        MODE_GRAY = 2'd3
    } mode_t;

    // Bits needed to hold a population count of an n-bit vector.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lp_bus_encoder_if.sv
// Source-side sample port and encoded bus lines of the low-power bus encoder.
interface lp_bus_encoder_if
    import lp_enc_pkg::*;
#(
    parameter int W = 8
);
    logic         in_valid;
    logic [W-1:0] din;
    mode_t        mode;
    logic [W-1:0] bus_out;
    logic         bus_extra;
    logic         out_valid;
    mode_t        last_mode;

    modport master (
        output in_valid, din, mode,
        input  bus_out, bus_extra, out_valid, last_mode
    );

    modport slave (
        input  in_valid, din, mode,
        output bus_out, bus_extra, out_valid, last_mode
    );
endinterface

// File: rtl/lp_bus_encoder_popcount.sv
// Combinational population count of an N-bit vector.
module lp_popcount
    import lp_enc_pkg::*;
#(
    parameter  int N     = 8,
    localparam int CNT_W = cnt_w(N)
) (
    input  logic [N-1:0]     vec,
    output logic [CNT_W-1:0] cnt
);
    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + CNT_W'(vec[i]);
        end
    end
endmodule

// File: rtl/lp_bus_encoder.sv
// Run-time selectable bus encoder (binary / bus-invert / T0 / Gray) with
// saturating switching-activity and sample counters.
module lp_bus_encoder
    import lp_enc_pkg::*;
#(
    parameter int W      = 8,
    parameter int STRIDE = 1,
    parameter int CW     = 24
) (
    input  logic            ck,
    input  logic            rst,
    lp_bus_encoder_if.slave bus,
    input  logic            clr_stats,
    output logic [CW-1:0]   toggles,
    output logic [CW-1:0]   samples,
    output logic            overflow
);
    localparam int            HW      = cnt_w(W);
    localparam int            DW      = cnt_w(W + 1);
    localparam logic [HW-1:0] HALF    = HW'(W / 2);
    localparam logic [W-1:0]  STEP    = W'(STRIDE);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [W-1:0]  bus_out_q, bus_out_d;
    logic          extra_q, extra_d;
    logic          out_valid_q, out_valid_d;
    logic [CW-1:0] toggles_q, toggles_d;
    logic [CW-1:0] samples_q, samples_d;
    logic          overflow_q, overflow_d;
    logic [W-1:0]  prev_din_q, prev_din_d;
    logic          t0_ok_q, t0_ok_d;
    mode_t         last_mode_q, last_mode_d;

    logic [W-1:0]  enc_bus;
    logic          enc_extra;
    logic [W-1:0]  t0_pred;
    logic [HW-1:0] ham;
    logic [DW-1:0] tog_delta;
    logic [CW:0]   tog_sum;

    assign t0_pred = prev_din_q + STEP;

    lp_popcount #(.N(W)) u_ham (
        .vec (bus.din ^ bus_out_q),
        .cnt (ham)
    );

    lp_popcount #(.N(W + 1)) u_tog (
        .vec ({enc_extra, enc_bus} ^ {extra_q, bus_out_q}),
        .cnt (tog_delta)
    );

    // Candidate encoding of the current input word.
    always_comb begin
        enc_bus   = bus.din;
        enc_extra = 1'b0;
        case (bus.mode)
            MODE_BIN:  enc_bus = bus.din;
            MODE_GRAY: enc_bus = bus.din ^ (bus.din >> 1);
            MODE_BINV: begin
                if (ham > HALF) begin
                    enc_bus   = ~bus.din;
                    enc_extra = 1'b1;
                end
            end
            MODE_T0: begin
                // A hit leaves the lines untouched; the decoder adds STRIDE itself.
                if (t0_ok_q && (bus.din == t0_pred)) begin
                    enc_bus   = bus_out_q;
                    enc_extra = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        bus_out_d   = bus_out_q;
        extra_d     = extra_q;
        out_valid_d = 1'b0;
        toggles_d   = toggles_q;
        samples_d   = samples_q;
        overflow_d  = overflow_q;
        prev_din_d  = prev_din_q;
        t0_ok_d     = t0_ok_q;
        last_mode_d = last_mode_q;
        tog_sum     = {1'b0, toggles_q} + (CW + 1)'(tog_delta);

        if (bus.in_valid) begin
            bus_out_d   = enc_bus;
            extra_d     = enc_extra;
            out_valid_d = 1'b1;
            prev_din_d  = bus.din;
            t0_ok_d     = (bus.mode == MODE_T0);
            last_mode_d = bus.mode;

            toggles_d = tog_sum[CW] ? CNT_MAX : tog_sum[CW-1:0];
            samples_d = (samples_q == CNT_MAX) ? CNT_MAX : samples_q + CNT_ONE;
            if ((toggles_d == CNT_MAX) || (samples_d == CNT_MAX)) begin
                overflow_d = 1'b1;
            end
        end

        // Clearing wins over counting a same-cycle sample.
        if (clr_stats) begin
            toggles_d  = '0;
            samples_d  = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            bus_out_q   <= '0;
            extra_q     <= 1'b0;
            out_valid_q <= 1'b0;
            toggles_q   <= '0;
            samples_q   <= '0;
            overflow_q  <= 1'b0;
            prev_din_q  <= '0;
            t0_ok_q     <= 1'b0;
            last_mode_q <= MODE_BIN;
        end else begin
            bus_out_q   <= bus_out_d;
            extra_q     <= extra_d;
            out_valid_q <= out_valid_d;
            toggles_q   <= toggles_d;
            samples_q   <= samples_d;
            overflow_q  <= overflow_d;
            prev_din_q  <= prev_din_d;
            t0_ok_q     <= t0_ok_d;
            last_mode_q <= last_mode_d;
        end
    end

    assign bus.bus_out   = bus_out_q;
    assign bus.bus_extra = extra_q;
    assign bus.out_valid = out_valid_q;
    assign bus.last_mode = last_mode_q;
    assign toggles       = toggles_q;
    assign samples       = samples_q;
    assign overflow      = overflow_q;
endmodule

// File: tb/tb_lp_bus_encoder.sv
// Directed and randomized checks of lp_bus_encoder against a word-level model;
// a second instance with 4-bit counters exercises saturation.
module tb_lp_bus_encoder;
    import lp_enc_pkg::*;

    localparam int W     = 8;
    localparam int CW_A  = 24;
    localparam int CW_B  = 4;
    localparam int MAX_A = (1 << CW_A) - 1;
    localparam int MAX_B = (1 << CW_B) - 1;

    logic            ck = 1'b0;
    logic            rst;
    logic            clr_stats;
    logic [CW_A-1:0] tog_a, smp_a;
    logic            ovf_a;
    logic [CW_B-1:0] tog_b, smp_b;
    logic            ovf_b;

    int n_checks = 0;
    int n_errors = 0;

    lp_bus_encoder_if #(.W(W)) if_a ();
    lp_bus_encoder_if #(.W(W)) if_b ();

    assign if_b.in_valid = if_a.in_valid;
    assign if_b.din      = if_a.din;
    assign if_b.mode     = if_a.mode;

    always #5 ck = ~ck;

    lp_bus_encoder #(.W(W), .STRIDE(1), .CW(CW_A)) u_dut (
        .ck        (ck),
        .rst       (rst),
        .bus       (if_a),
        .clr_stats (clr_stats),
        .toggles   (tog_a),
        .samples   (smp_a),
        .overflow  (ovf_a)
    );

    lp_bus_encoder #(.W(W), .STRIDE(1), .CW(CW_B)) u_sat (
        .ck        (ck),
        .rst       (rst),
        .bus       (if_b),
        .clr_stats (clr_stats),
        .toggles   (tog_b),
        .samples   (smp_b),
        .overflow  (ovf_b)
    );

    // Word-level reference state; counts are kept unsaturated since the last clear.
    logic [7:0] m_bus, m_prev;
    logic       m_extra, m_t0ok, m_valid;
    int         m_last, true_tog, true_smp;

    function automatic int sat(input int x, input int mx);
        return (x > mx) ? mx : x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bus = '0; m_prev = '0; m_extra = 0; m_t0ok = 0; m_valid = 0;
        m_last = 0; true_tog = 0; true_smp = 0;
    endtask

    task automatic model_apply(input logic v, input logic [7:0] d, input int md, input logic clr);
        logic [7:0] nb;
        logic       ne;
        logic [7:0] nxt;
        m_valid = v;
        if (v) begin
            nb = d; ne = 1'b0;
            nxt = m_prev + 8'd1;
            if (md == 3) nb = d ^ (d >> 1);
            else if (md == 1 && $countones(d ^ m_bus) > W / 2) begin nb = ~d; ne = 1'b1; end
            else if (md == 2 && m_t0ok && d == nxt) begin nb = m_bus; ne = 1'b1; end
            if (!clr) begin
                true_tog += $countones({ne, nb} ^ {m_extra, m_bus});
                true_smp += 1;
            end
            m_bus = nb; m_extra = ne; m_prev = d; m_t0ok = (md == 2); m_last = md;
        end
        if (clr) begin true_tog = 0; true_smp = 0; end
    endtask

    task automatic compare_all();
        check("bus_a",   32'(if_a.bus_out),   32'(m_bus));
        check("extra_a", 32'(if_a.bus_extra), 32'(m_extra));
        check("valid_a", 32'(if_a.out_valid), 32'(m_valid));
        check("mode_a",  32'(if_a.last_mode), 32'(m_last));
        check("tog_a",   32'(tog_a), 32'(sat(true_tog, MAX_A)));
        check("smp_a",   32'(smp_a), 32'(sat(true_smp, MAX_A)));
        check("ovf_a",   32'(ovf_a), 32'(true_tog >= MAX_A || true_smp >= MAX_A));
        check("bus_b",   32'(if_b.bus_out),   32'(m_bus));
        check("tog_b",   32'(tog_b), 32'(sat(true_tog, MAX_B)));
        check("smp_b",   32'(smp_b), 32'(sat(true_smp, MAX_B)));
        check("ovf_b",   32'(ovf_b), 32'(true_tog >= MAX_B || true_smp >= MAX_B));
    endtask

    task automatic step(input logic v, input logic [7:0] d, input int md, input logic clr);
        logic [1:0] m2;
        m2 = 2'(md);
        if_a.in_valid = v;
        if_a.din      = d;
        if_a.mode     = mode_t'(m2);
        clr_stats     = clr;
        @(posedge ck);
        #1;
        model_apply(v, d, md, clr);
        compare_all();
    endtask

    task automatic expect_bus(input string tag, input logic [7:0] b, input logic e);
        check({tag, "_bus"},   32'(if_a.bus_out),   32'(b));
        check({tag, "_extra"}, 32'(if_a.bus_extra), 32'(e));
    endtask

    initial begin
        logic [7:0] d;
        int         md;
        logic       v, c;

        rst = 1'b0; clr_stats = 1'b0;
        if_a.in_valid = 1'b0; if_a.din = '0; if_a.mode = MODE_BIN;
        model_reset();
        repeat (2) @(posedge ck);
        #1;
        compare_all();
        rst = 1'b1;

        repeat (5) step(1'b0, 8'h00, 0, 1'b0);

        // Gray on a counting stream
        for (int i = 0; i < 8; i++) step(1'b1, 8'(i), 3, 1'b0);
        expect_bus("gray7", 8'h04, 1'b0);
        check("gray_tog", 32'(tog_a), 32'd7);
        check("gray_smp", 32'(smp_a), 32'd8);

        // Bus-invert from an all-zero bus, including the tie case
        step(1'b1, 8'h00, 0, 1'b0);
        step(1'b0, 8'h00, 0, 1'b1);
        step(1'b1, 8'hFF, 1, 1'b0);
        expect_bus("binv_ff", 8'h00, 1'b1);
        step(1'b1, 8'h0F, 1, 1'b0);
        expect_bus("binv_tie", 8'h0F, 1'b0);
        check("binv_tog", 32'(tog_a), 32'd6);

        // T0 hits, miss, and wrap-around hit
        step(1'b1, 8'h3E, 2, 1'b0); expect_bus("t0_3e", 8'h3E, 1'b0);
        step(1'b1, 8'h3F, 2, 1'b0); expect_bus("t0_3f", 8'h3E, 1'b1);
        step(1'b1, 8'h40, 2, 1'b0); expect_bus("t0_40", 8'h3E, 1'b1);
        step(1'b1, 8'h00, 2, 1'b0); expect_bus("t0_00", 8'h00, 1'b0);
        step(1'b1, 8'hFF, 2, 1'b0); expect_bus("t0_ff", 8'hFF, 1'b0);
        step(1'b1, 8'h00, 2, 1'b0); expect_bus("t0_wrap", 8'hFF, 1'b1);

        // Switching into T0 never hits on the first sample
        step(1'b1, 8'h10, 0, 1'b0); expect_bus("sw_10", 8'h10, 1'b0);
        step(1'b1, 8'h11, 2, 1'b0); expect_bus("sw_11", 8'h11, 1'b0);
        step(1'b1, 8'h12, 2, 1'b0); expect_bus("sw_12", 8'h11, 1'b1);

        // Saturation of the 4-bit counters, then clear with a same-cycle sample
        step(1'b0, 8'h00, 0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 3, 1'b0);
        check("sat_smp", 32'(smp_b), 32'd15);
        check("sat_ovf", 32'(ovf_b), 32'd1);
        step(1'b1, 8'h55, 3, 1'b1);
        check("clr_tog", 32'(tog_b), 32'd0);
        check("clr_smp", 32'(smp_b), 32'd0);
        check("clr_ovf", 32'(ovf_b), 32'd0);
        expect_bus("clr_bus", 8'h7F, 1'b0);

        // Randomized traffic, biased towards T0 hits
        for (int i = 0; i < 300; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            md = int'($urandom_range(0, 3));
            d  = 8'($urandom);
            if (md == 2 && $urandom_range(0, 2) != 0) d = m_prev + 8'd1;
            c  = ($urandom_range(0, 15) == 0);
            step(v, d, md, c);
        end

        // Asynchronous reset mid-stream
        if_a.in_valid = 1'b0;
        clr_stats     = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge ck);
        #1 rst = 1'b1;
        step(1'b1, 8'h21, 2, 1'b0); expect_bus("rst_t0", 8'h21, 1'b0);
        step(1'b1, 8'h22, 2, 1'b0); expect_bus("rst_t0_hit", 8'h21, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/lp_bus_encoder.md
Name: lp_bus_encoder

Overview:
- Parametrised low-power bus encoder, successor to the fixed 8-bit single-scheme encoders (binary, bus-invert, T0, Gray).
- One instance supports all four schemes, selectable at run time, at any bus width.
- Contains on-chip switching-activity counters, so toggle counts are available without a gate-level power run.
- Sits between an address/data source and a long, high-capacitance bus. A matching decoder sits at the far end.

Parameters:
- W, 8, width of the data/address bus (W >= 2, even).
- STRIDE, 1, T0 expected address increment (mod 2^W).
- CW, 24, width of the activity and sample counters.

Ports:
- ck  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  din is a new sample this cycle.
- din  in  W  raw address/data word.
- mode  in  2  0=BINARY, 1=BUSINV, 2=T0, 3=GRAY; sampled with each valid sample.
- clr_stats  in  1  synchronous clear of the counters and the overflow flag.
- bus_out  out  W  encoded bus lines (registered).
- bus_extra  out  1  redundant line: INV for BUSINV, INC for T0, 0 otherwise.
- out_valid  out  1  bus_out/bus_extra carry a new encoded word this cycle.
- toggles  out  CW  cumulative transitions on {bus_extra, bus_out}.
- samples  out  CW  number of encoded samples.
- overflow  out  1  sticky; set when either counter saturates.

Behaviour:
- Reset (rst=0, async): every register is 0, namely bus_out, bus_extra, out_valid, toggles, samples, overflow, prev_din, t0_ok and last_mode.
- Latency: 1 cycle. A sample accepted at edge N appears on bus_out at edge N, with out_valid=1 for that cycle.
- in_valid=0: bus_out and bus_extra hold their previous values (no activity), and out_valid=0.
- BINARY: bus_out=din, extra=0.
- GRAY: bus_out = din ^ (din>>1), extra=0.
- BUSINV:
  - H = popcount(din ^ bus_out), computed over the W data lines only.
  - If H > W/2: bus_out=~din, extra=1.
  - Otherwise (ties included): bus_out=din, extra=0.
- T0:
  - Hit when t0_ok=1 and din == prev_din + STRIDE (mod 2^W, wrap-around counts as a hit).
  - On a hit, bus_out holds and extra=1.
  - On a miss, bus_out=din and extra=0.
- prev_din <= din on every valid sample, in every mode.
- t0_ok register:
  - Set to 1 after a valid sample in T0 mode.
  - Cleared by reset and by any valid sample taken in a mode other than T0.
  - Consequence: the first T0 sample after reset or after a mode switch is never a hit, so the decoder always has a base address.
- Mode switch: takes effect on the valid sample that carries the new mode value; there is no flush. last_mode records the mode of the previous valid sample, for debug.
- Activity counting:
  - On each valid sample, toggles += popcount({extra_next, bus_next} ^ {bus_extra, bus_out}), an adder of width $clog2(W+2); samples += 1.
  - Both counters saturate at 2^CW-1.
  - Reaching saturation sets overflow, which stays set until clr_stats or reset.
- clr_stats priority: when clr_stats=1, toggles, samples and overflow are 0 after the edge. A valid sample in the same cycle is still encoded onto the bus, but it is not counted.
- Reset mid-stream: the bus drops to 0 immediately. This drop is not counted as a transition.

Decomposition:
- Package lp_enc_pkg holds:
  - mode constants MODE_BIN, MODE_BINV, MODE_T0, MODE_GRAY;
  - the 2-bit mode type;
  - function clog2-based width helpers.
- Sub-module lp_popcount, parametrised width N, purely combinational. It is instantiated twice: once for the BUSINV Hamming distance and once for the toggle delta.
- The encoder core and counters stay in lp_bus_encoder.

Test Plan:
- Reset, then hold in_valid=0 for 5 cycles -> bus_out=0, extra=0, toggles=0, samples=0, out_valid=0 throughout.
- W=8, GRAY: din 0..7 consecutive -> bus_out 00,01,03,02,06,07,05,04; toggles=7, samples=8.
- W=8, BUSINV from bus=00: din=FF -> bus=00, extra=1. Then din=0F (H=4 vs 00, a tie) -> bus=0F, extra=0. toggles = 1 + 5 = 6.
- W=8, T0, STRIDE=1:
  - din 3E,3F,40 -> bus 3E/0, 3E/1, 3E/1.
  - Then din 00 -> bus 00/0.
  - Wrap case: din FF then 00 -> the second sample is a hit.
- Mode switch BINARY->T0: din 10 in BINARY, then 11 in T0 -> no hit (t0_ok=0), bus=11/0. Next din 12 -> hit.
- CW=4: run 20 GRAY samples on a counting stream -> samples=15 and overflow=1. Then clr_stats together with a valid sample -> counters=0, overflow=0, and the bus is still updated.
